// File: rtl/pipe_datapath.sv
// pipe_datapath: four-stage (ID, EX, MEM, WB) integer pipeline.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   inst          instruction word {opc[31:26], rs1[25:21], rs2[20:16], rd[15:11]}, imm[15:0], jtarget[25:0]
//   inst_pc       address of inst
//   inst_valid    inst/inst_pc carry an instruction
//   inst_ready    pipeline accepts inst at the next rising edge
//   br_taken      redirect fetch this cycle (branch/jump resolved in EX)
//   br_target     redirect address, 0 when br_taken is 0
//   dm_addr       data memory address (MEM ALU result, 0 when MEM idle)
//   dm_wdata      store data
//   dm_we         store strobe
//   dm_rdata      load data, combinational from dm_addr
//   retire_count  count of instructions leaving WB
//
// Parameters:
//   XLEN    datapath width (32 or 64)
//   FWD_EN  1: forward MEM/WB results into EX; 0: stall on every RAW hazard
module pipe_datapath #(
    parameter int XLEN   = 32,
    parameter int FWD_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     inst,
    input  logic [31:0]     inst_pc,
    input  logic            inst_valid,
    output logic            inst_ready,
    output logic            br_taken,
    output logic [31:0]     br_target,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    output logic            dm_we,
    input  logic [XLEN-1:0] dm_rdata,
    output logic [31:0]     retire_count
);

    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_LOAD  = 6'd4;
    localparam logic [5:0] OP_AND   = 6'd12;
    localparam logic [5:0] OP_OR    = 6'd13;
    localparam logic [5:0] OP_XOR   = 6'd14;
    localparam logic [5:0] OP_MOVEI = 6'd16;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_BEQ   = 6'd21;
    localparam logic [5:0] OP_JUMP  = 6'd22;

    localparam bit FWD = (FWD_EN != 0);

    // ---------------- state ----------------
    logic [XLEN-1:0] rf_q [32];

    logic            id_valid_q, id_valid_d;
    logic [31:0]     id_inst_q, id_inst_d;
    logic [31:0]     id_pc_q, id_pc_d;

    logic            ex_valid_q, ex_valid_d;
    logic [5:0]      ex_opc_q;
    logic [25:0]     ex_low_q;
    logic [31:0]     ex_pc_q;
    logic [4:0]      ex_rs1_q, ex_rs2_q, ex_dst_q;
    logic            ex_wr_q;
    logic [XLEN-1:0] ex_a_q, ex_b_q;

    logic            mem_valid_q, mem_st_q, mem_ld_q, mem_wr_q;
    logic [4:0]      mem_dst_q;
    logic [XLEN-1:0] mem_res_q, mem_sd_q;

    logic            wb_valid_q, wb_wr_q;
    logic [4:0]      wb_dst_q;
    logic [XLEN-1:0] wb_res_q;

    logic [31:0]     retire_q, retire_d;

    // ---------------- ID: decode, register read, hazard ----------------
    logic [5:0]      id_opc;
    logic [4:0]      id_rs1, id_rs2, id_rd, id_dst;
    logic            id_use1, id_use2, id_wr;
    logic [XLEN-1:0] id_a, id_b;
    logic            wb_wr, ex_dep, mem_dep, hazard, stall;

    assign id_opc = id_inst_q[31:26];
    assign id_rs1 = id_inst_q[25:21];
    assign id_rs2 = id_inst_q[20:16];
    assign id_rd  = id_inst_q[15:11];

    always_comb begin
        id_use1 = 1'b0;
        id_use2 = 1'b0;
        id_wr   = 1'b0;
        id_dst  = id_rd;
        case (id_opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                id_use1 = 1'b1; id_use2 = 1'b1; id_wr = 1'b1;
            end
            OP_STORE, OP_BEQ: begin
                id_use1 = 1'b1; id_use2 = 1'b1;
            end
            OP_LOAD, OP_ADDI: begin
                id_use1 = 1'b1; id_wr = 1'b1; id_dst = id_rs2;
            end
            OP_MOVEI: begin
                id_wr = 1'b1; id_dst = id_rs2;
            end
            default: ;
        endcase
    end

    // A WB write to the register being read in ID is visible the same cycle.
    assign wb_wr = wb_valid_q && wb_wr_q && (wb_dst_q != 5'd0);
    assign id_a  = (id_rs1 == 5'd0) ? '0 :
                   (wb_wr && wb_dst_q == id_rs1) ? wb_res_q : rf_q[id_rs1];
    assign id_b  = (id_rs2 == 5'd0) ? '0 :
                   (wb_wr && wb_dst_q == id_rs2) ? wb_res_q : rf_q[id_rs2];

    assign ex_dep  = ex_valid_q && ex_wr_q && (ex_dst_q != 5'd0) &&
                     ((id_use1 && id_rs1 == ex_dst_q) || (id_use2 && id_rs2 == ex_dst_q));
    assign mem_dep = mem_valid_q && mem_wr_q && (mem_dst_q != 5'd0) &&
                     ((id_use1 && id_rs1 == mem_dst_q) || (id_use2 && id_rs2 == mem_dst_q));
    // With forwarding only a load in EX cannot reach the consumer in time.
    assign hazard  = FWD ? (ex_dep && ex_opc_q == OP_LOAD) : (ex_dep || mem_dep);
    // A taken branch flushes ID anyway, so it wins over a stall.
    assign stall   = id_valid_q && hazard && !br_taken;

    // Handshake: an instruction transfers on a rising edge where inst_valid
    // and inst_ready are both 1; inst_ready depends only on pipeline state,
    // never on inst_valid. A transfer in a br_taken cycle is dropped.
    assign inst_ready = reset && !stall;

    always_comb begin
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        if (br_taken) begin
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_valid_d = inst_valid;
            id_inst_d  = inst;
            id_pc_d    = inst_pc;
        end
    end

    assign ex_valid_d = id_valid_q && !stall && !br_taken;

    // ---------------- EX: forwarding, ALU, branch ----------------
    logic            mem_fwd, wb_fwd;
    logic [XLEN-1:0] mem_val, ex_a, ex_b, ex_imm, ex_res;
    logic [31:0]     ex_tgt;

    assign mem_fwd = FWD && mem_valid_q && mem_wr_q && (mem_dst_q != 5'd0);
    assign wb_fwd  = FWD && wb_wr;
    assign mem_val = mem_ld_q ? dm_rdata : mem_res_q;
    assign ex_a    = (mem_fwd && mem_dst_q == ex_rs1_q) ? mem_val :
                     (wb_fwd && wb_dst_q == ex_rs1_q)   ? wb_res_q : ex_a_q;
    assign ex_b    = (mem_fwd && mem_dst_q == ex_rs2_q) ? mem_val :
                     (wb_fwd && wb_dst_q == ex_rs2_q)   ? wb_res_q : ex_b_q;
    assign ex_imm  = {{(XLEN-16){ex_low_q[15]}}, ex_low_q[15:0]};

    always_comb begin
        ex_res    = '0;
        br_taken  = 1'b0;
        br_target = 32'd0;
        ex_tgt    = ex_pc_q + {{16{ex_low_q[15]}}, ex_low_q[15:0]};
        case (ex_opc_q)
            OP_ADD:                      ex_res = ex_a + ex_b;
            OP_SUB:                      ex_res = ex_a - ex_b;
            OP_AND:                      ex_res = ex_a & ex_b;
            OP_OR:                       ex_res = ex_a | ex_b;
            OP_XOR:                      ex_res = ex_a ^ ex_b;
            OP_STORE, OP_LOAD, OP_ADDI:  ex_res = ex_a + ex_imm;
            OP_MOVEI:                    ex_res = ex_imm;
            default: ;
        endcase
        if (ex_valid_q && ex_opc_q == OP_BEQ && ex_a == ex_b) begin
            br_taken  = 1'b1;
            br_target = ex_tgt;
        end
        if (ex_valid_q && ex_opc_q == OP_JUMP) begin
            br_taken  = 1'b1;
            br_target = {6'd0, ex_low_q};
        end
    end

    // ---------------- MEM / WB outputs ----------------
    assign dm_we    = mem_valid_q && mem_st_q;
    assign dm_addr  = mem_valid_q ? mem_res_q : '0;
    assign dm_wdata = dm_we ? mem_sd_q : '0;

    assign retire_d     = retire_q + 32'(wb_valid_q);
    assign retire_count = retire_q;

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid_q  <= 1'b0;
            id_inst_q   <= '0;
            id_pc_q     <= '0;
            ex_valid_q  <= 1'b0;
            ex_opc_q    <= '0;
            ex_low_q    <= '0;
            ex_pc_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_dst_q    <= '0;
            ex_wr_q     <= 1'b0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            mem_valid_q <= 1'b0;
            mem_st_q    <= 1'b0;
            mem_ld_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_dst_q   <= '0;
            mem_res_q   <= '0;
            mem_sd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_wr_q     <= 1'b0;
            wb_dst_q    <= '0;
            wb_res_q    <= '0;
            retire_q    <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_inst_q   <= id_inst_d;
            id_pc_q     <= id_pc_d;
            ex_valid_q  <= ex_valid_d;
            ex_opc_q    <= id_opc;
            ex_low_q    <= id_inst_q[25:0];
            ex_pc_q     <= id_pc_q;
            ex_rs1_q    <= id_rs1;
            ex_rs2_q    <= id_rs2;
            ex_dst_q    <= id_dst;
            ex_wr_q     <= id_wr;
            ex_a_q      <= id_a;
            ex_b_q      <= id_b;
            mem_valid_q <= ex_valid_q;
            mem_st_q    <= (ex_opc_q == OP_STORE);
            mem_ld_q    <= (ex_opc_q == OP_LOAD);
            mem_wr_q    <= ex_wr_q;
            mem_dst_q   <= ex_dst_q;
            mem_res_q   <= ex_res;
            mem_sd_q    <= ex_b;
            wb_valid_q  <= mem_valid_q;
            wb_wr_q     <= mem_wr_q;
            wb_dst_q    <= mem_dst_q;
            wb_res_q    <= mem_val;
            retire_q    <= retire_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_wr) begin
            rf_q[wb_dst_q] <= wb_res_q;
        end
    end

endmodule

// File: tb/tb_pipe_datapath.sv
// Directed bench for pipe_datapath: one forwarding instance (dut_f) and one
// stall-only instance (dut_s). Stores are the observation point for register
// values: each expected {addr, data} is queued when the STORE is issued and
// popped when dm_we is seen.
module tb_pipe_datapath;

  localparam logic [5:0] OP_ADD = 6'd1, OP_SUB = 6'd2, OP_STORE = 6'd3, OP_LOAD = 6'd4;
  localparam logic [5:0] OP_AND = 6'd12, OP_OR = 6'd13, OP_XOR = 6'd14;
  localparam logic [5:0] OP_MOVEI = 6'd16, OP_ADDI = 6'd19, OP_BEQ = 6'd21, OP_JUMP = 6'd22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [31:0] inst_f, pc_f, inst_s, pc_s;
  logic        valid_f, valid_s, ready_f, ready_s;
  logic        brt_f, brt_s, dmwe_f, dmwe_s;
  logic [31:0] brtg_f, brtg_s, dma_f, dma_s, dmw_f, dmw_s, dmr_f, dmr_s, ret_f, ret_s;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return (a == 32'd8) ? 32'h0000_002A : (a ^ 32'hA5A5_0000);
  endfunction
  assign dmr_f = mem_read(dma_f);
  assign dmr_s = mem_read(dma_s);

  pipe_datapath #(.XLEN(32), .FWD_EN(1)) dut_f (
    .clk(clk), .reset(reset), .inst(inst_f), .inst_pc(pc_f), .inst_valid(valid_f),
    .inst_ready(ready_f), .br_taken(brt_f), .br_target(brtg_f), .dm_addr(dma_f),
    .dm_wdata(dmw_f), .dm_we(dmwe_f), .dm_rdata(dmr_f), .retire_count(ret_f));

  pipe_datapath #(.XLEN(32), .FWD_EN(0)) dut_s (
    .clk(clk), .reset(reset), .inst(inst_s), .inst_pc(pc_s), .inst_valid(valid_s),
    .inst_ready(ready_s), .br_taken(brt_s), .br_target(brtg_s), .dm_addr(dma_s),
    .dm_wdata(dmw_s), .dm_we(dmwe_s), .dm_rdata(dmr_s), .retire_count(ret_s));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q_f[$];
  logic [63:0] exp_q_s[$];
  logic [31:0] exp_retire_f = 0;
  logic [31:0] exp_retire_s = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dmwe_f) begin
      n_checks++;
      assert (exp_q_f.size() != 0) else begin
        n_errors++;
        $error("FAIL store_f_unexpected: observed addr %0h data %0h, expected no store", dma_f, dmw_f);
      end
      if (exp_q_f.size() != 0) check("store_f", {dma_f, dmw_f}, exp_q_f.pop_front());
    end
    if (dmwe_s) begin
      n_checks++;
      assert (exp_q_s.size() != 0) else begin
        n_errors++;
        $error("FAIL store_s_unexpected: observed addr %0h data %0h, expected no store", dma_s, dmw_s);
      end
      if (exp_q_s.size() != 0) check("store_s", {dma_s, dmw_s}, exp_q_s.pop_front());
    end
  end

  // ---------------- encoders / model helpers ----------------
  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rs1, rs2, rd, 11'd0};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [15:0] imm);
    return {op, rs1, rs2, imm};
  endfunction
  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge. stalls = cycles with ready low.
  task automatic issue(input bit sel, input logic [31:0] ins, input logic [31:0] pc,
                       input bit retires, output int stalls);
    stalls = 0;
    if (sel) begin inst_s = ins; pc_s = pc; valid_s = 1'b1; end
    else     begin inst_f = ins; pc_f = pc; valid_f = 1'b1; end
    #1;
    while (!(sel ? ready_s : ready_f) && stalls < 40) begin
      @(negedge clk); #1;
      stalls++;
    end
    n_checks++;
    assert (stalls < 40) else begin
      n_errors++;
      $error("FAIL ready_timeout: observed %0d stall cycles, expected fewer than 40", stalls);
    end
    @(negedge clk);
    if (sel) valid_s = 1'b0; else valid_f = 1'b0;
    if (retires) begin
      if (sel) exp_retire_s++; else exp_retire_f++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  ready_f, 0);
    check({tag, "_brt"},    brt_f,   0);
    check({tag, "_brtg"},   brtg_f,  0);
    check({tag, "_dmwe"},   dmwe_f,  0);
    check({tag, "_dma"},    dma_f,   0);
    check({tag, "_dmw"},    dmw_f,   0);
    check({tag, "_retire"}, ret_f,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int st;
    logic [15:0] ia, ib, ic;
    logic [31:0] ea, eb, ev;
    logic [5:0]  ops[5];
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};

    reset = 1'b0;
    valid_f = 1'b0; inst_f = '0; pc_f = '0;
    valid_s = 1'b0; inst_s = '0; pc_s = '0;
    idle(3);
    check_reset_outputs("in_reset");
    reset = 1'b1;
    #1 check("ready_after_reset", ready_f, 1);
    @(negedge clk);

    // Back-to-back forwarding: r3 = 5 + 7, no stalls.
    issue(0, enc_i(OP_MOVEI, 5'd0, 5'd1, 16'd5), 32'h0, 1, st);
    issue(0, enc_i(OP_MOVEI, 5'd0, 5'd2, 16'd7), 32'h4, 1, st);
    issue(0, enc_r(OP_ADD, 5'd3, 5'd1, 5'd2), 32'h8, 1, st);
    check("fwd_add_stalls", st, 0);
    exp_q_f.push_back({32'h100, 32'd12});
    issue(0, enc_i(OP_STORE, 5'd0, 5'd3, 16'h0100), 32'hC, 1, st);
    check("fwd_store_stalls", st, 0);
    idle(6);
    check("retire_prog1", ret_f, exp_retire_f);

    // Load-use: one stall cycle, r5 = 0x2A + 0x2A.
    issue(0, enc_i(OP_LOAD, 5'd0, 5'd4, 16'd8), 32'h20, 1, st);
    issue(0, enc_r(OP_ADD, 5'd5, 5'd4, 5'd4), 32'h24, 1, st);
    exp_q_f.push_back({32'h104, 32'h54});
    issue(0, enc_i(OP_STORE, 5'd0, 5'd5, 16'h0104), 32'h28, 1, st);
    check("load_use_stalls", st, 1);

    // ALU ops on random sign-extended operands, results stored immediately.
    ia = 16'($urandom_range(0, 65535));
    ib = 16'($urandom_range(0, 65535));
    ic = 16'($urandom_range(0, 65535));
    ea = sx(ia);
    eb = sx(ib);
    issue(0, enc_i(OP_MOVEI, 5'd0, 5'd7, ia), 32'h30, 1, st);
    issue(0, enc_i(OP_MOVEI, 5'd0, 5'd8, ib), 32'h34, 1, st);
    for (int i = 0; i < 5; i++) begin
      case (ops[i])
        OP_ADD:  ev = ea + eb;
        OP_SUB:  ev = ea - eb;
        OP_AND:  ev = ea & eb;
        OP_OR:   ev = ea | eb;
        default: ev = ea ^ eb;
      endcase
      issue(0, enc_r(ops[i], 5'd9, 5'd7, 5'd8), 32'h40, 1, st);
      exp_q_f.push_back({32'h110 + 32'(4 * i), ev});
      issue(0, enc_i(OP_STORE, 5'd0, 5'd9, 16'h0110 + 16'(4 * i)), 32'h44, 1, st);
    end
    issue(0, enc_i(OP_ADDI, 5'd7, 5'd10, ic), 32'h50, 1, st);
    exp_q_f.push_back({32'h130, ea + sx(ic)});
    issue(0, enc_i(OP_STORE, 5'd0, 5'd10, 16'h0130), 32'h54, 1, st);
    exp_q_f.push_back({32'h105, ea + sx(ic)});
    issue(0, enc_i(OP_STORE, 5'd1, 5'd10, 16'h0100), 32'h58, 1, st);
    idle(6);
    check("retire_alu", ret_f, exp_retire_f);

    // Taken BEQ at 0x10: two following slots are squashed.
    issue(0, enc_i(OP_BEQ, 5'd0, 5'd0, 16'd4), 32'h10, 1, st);
    check("beq_in_id_brt", brt_f, 0);
    issue(0, enc_i(OP_MOVEI, 5'd0, 5'd11, 16'h0077), 32'h14, 0, st);
    check("beq_brt", brt_f, 1);
    check("beq_target", brtg_f, 32'h14);
    issue(0, enc_i(OP_STORE, 5'd0, 5'd11, 16'h0200), 32'h18, 0, st);
    check("beq_after_brt", brt_f, 0);
    check("beq_after_target", brtg_f, 0);
    idle(6);
    check("retire_beq", ret_f, exp_retire_f);

    // JUMP: zero-extended target, two slots squashed.
    issue(0, {OP_JUMP, 26'h0000123}, 32'h60, 1, st);
    issue(0, enc_i(OP_MOVEI, 5'd0, 5'd11, 16'h0099), 32'h64, 0, st);
    check("jump_brt", brt_f, 1);
    check("jump_target", brtg_f, 32'h123);
    issue(0, enc_i(OP_MOVEI, 5'd0, 5'd11, 16'h0098), 32'h68, 0, st);

    // Not-taken BEQ with a forwarded operand.
    issue(0, enc_i(OP_MOVEI, 5'd0, 5'd12, 16'd1), 32'h123, 1, st);
    issue(0, enc_i(OP_BEQ, 5'd0, 5'd12, 16'd8), 32'h127, 1, st);
    issue(0, enc_i(OP_MOVEI, 5'd0, 5'd14, 16'd3), 32'h12B, 1, st);
    check("beq_nt_brt", brt_f, 0);
    check("beq_nt_target", brtg_f, 0);
    exp_q_f.push_back({32'h204, 32'd0});
    issue(0, enc_i(OP_STORE, 5'd0, 5'd11, 16'h0204), 32'h12F, 1, st);
    exp_q_f.push_back({32'h208, 32'd3});
    issue(0, enc_i(OP_STORE, 5'd0, 5'd14, 16'h0208), 32'h133, 1, st);
    idle(6);
    check("retire_branches", ret_f, exp_retire_f);

    // Writes to r0 are discarded.
    issue(0, enc_i(OP_MOVEI, 5'd0, 5'd0, 16'd9), 32'h140, 1, st);
    issue(0, enc_r(OP_ADD, 5'd6, 5'd0, 5'd0), 32'h144, 1, st);
    exp_q_f.push_back({32'h300, 32'd0});
    issue(0, enc_i(OP_STORE, 5'd0, 5'd6, 16'h0300), 32'h148, 1, st);
    exp_q_f.push_back({32'h304, 32'd0});
    issue(0, enc_i(OP_STORE, 5'd0, 5'd0, 16'h0304), 32'h14C, 1, st);
    idle(6);
    check("retire_r0", ret_f, exp_retire_f);

    // Stall-only instance: ADD waits two cycles in ID.
    issue(1, enc_i(OP_MOVEI, 5'd0, 5'd1, 16'd5), 32'h0, 1, st);
    issue(1, enc_i(OP_MOVEI, 5'd0, 5'd2, 16'd7), 32'h4, 1, st);
    issue(1, enc_r(OP_ADD, 5'd3, 5'd1, 5'd2), 32'h8, 1, st);
    exp_q_s.push_back({32'h100, 32'd12});
    issue(1, enc_i(OP_STORE, 5'd0, 5'd3, 16'h0100), 32'hC, 1, st);
    check("nofwd_add_stalls", st, 2);
    idle(8);
    check("retire_nofwd", ret_s, exp_retire_s);

    // Reset while a STORE sits in EX: the store never reaches memory.
    issue(0, enc_i(OP_MOVEI, 5'd0, 5'd13, 16'h0055), 32'h400, 1, st);
    issue(0, enc_i(OP_STORE, 5'd0, 5'd13, 16'h0400), 32'h404, 1, st);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid_reset");
    idle(2);
    reset = 1'b1;
    #1 check("ready_after_midreset", ready_f, 1);
    exp_retire_f = 0;
    idle(6);
    check("retire_after_midreset", ret_f, 0);
    exp_q_f.push_back({32'h404, 32'd0});
    issue(0, enc_i(OP_STORE, 5'd0, 5'd13, 16'h0404), 32'h0, 1, st);
    idle(6);
    check("retire_final", ret_f, exp_retire_f);

    check("store_q_f_empty", 64'(exp_q_f.size()), 0);
    check("store_q_s_empty", 64'(exp_q_s.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter FWD_EN, default 1, meaning 1 enables operand forwarding and 0 resolves every RAW hazard by stalling.
REQ-003 SHALL have port clk  input  1  meaning the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port inst  input  32  meaning the instruction word, fields [31:26] opc, [25:21] rs1, [20:16] rs2, [15:11] rd, [15:0] imm, [25:0] jtarget.
REQ-006 SHALL have port inst_pc  input  32  meaning the address of inst.
REQ-007 SHALL have port inst_valid  input  1  meaning inst and inst_pc are valid.
REQ-008 SHALL have port inst_ready  output  1  meaning the block accepts inst on this edge.
REQ-009 SHALL have port br_taken  output  1  meaning redirect fetch this cycle.
REQ-010 SHALL have port br_target  output  32  meaning the redirect address.
REQ-011 SHALL have port dm_addr  output  XLEN  meaning the data memory address.
REQ-012 SHALL have port dm_wdata  output  XLEN  meaning the store data.
REQ-013 SHALL have port dm_we  output  1  meaning the store strobe.
REQ-014 SHALL have port dm_rdata  input  XLEN  meaning load data, combinational from dm_addr in the same cycle.
REQ-015 SHALL have port retire_count  output  32  meaning the number of instructions written back or completed.

Function
REQ-016 SHALL implement four stages, ID (register read and hazard check), EX (ALU and branch), MEM and WB, each carrying a valid bit.
REQ-017 SHALL support the opcodes 0 NOP; 1 ADD; 2 SUB; 12 AND; 13 OR; 14 XOR (rd = rs1 op rs2); 3 STORE (mem[rs1+sext(imm)] = rs2); 4 LOAD (rs2 = mem[rs1+sext(imm)]); 16 MOVEI (rs2 = sext(imm)); 19 ADDI (rs2 = rs1+sext(imm)); 21 BEQ (if rs1==rs2, pc = inst_pc+sext(imm)); 22 JUMP (pc = zext(jtarget)).
REQ-018 SHALL execute any other opcode as NOP; such an instruction still counts as retired.
REQ-019 SHALL sign-extend imm from bit 15 to XLEN, and SHALL wrap all arithmetic modulo 2^XLEN.
REQ-020 SHALL hold a register file of 32 entries x XLEN; r0 SHALL read as 0 and writes to r0 SHALL be discarded.
REQ-021 SHALL write the register file in WB; a read in ID of the same register in the same cycle SHALL return the WB value (write-through).
REQ-022 SHALL, when FWD_EN=1, forward to EX operands with priority MEM over WB, using the load data (dm_rdata) for a load in MEM.
REQ-023 SHALL, when FWD_EN=1, stall ID 1 cycle on load-use: an ID source equals the destination of a valid LOAD in EX with nonzero register number.
REQ-024 SHALL, when FWD_EN=0, stall ID while any valid EX or MEM instruction writes a nonzero register that ID reads.
REQ-025 SHALL, on a stall, drive inst_ready=0, hold the ID register, and inject a bubble (valid=0) into EX.
REQ-026 SHALL drive inst_ready = !stall.
REQ-027 SHALL resolve branches in EX, with br_taken combinational and br_target = computed PC, both 0 when no branch or jump is taken.
REQ-028 SHALL, when br_taken=1, invalidate ID at the next edge and discard any inst accepted in that cycle (2-slot penalty); the flush SHALL override a stall.
REQ-029 SHALL assert dm_we only for a valid STORE in MEM.
REQ-030 SHALL drive dm_addr from the MEM ALU result when MEM is valid, and 0 otherwise.
REQ-031 SHALL increment retire_count by 1 for each valid instruction leaving WB, wrapping at 2^32.

Reset
REQ-032 SHALL, while reset=0, asynchronously clear all stage valid bits, pipeline registers, register file and retire_count.
REQ-033 SHALL, while reset=0, drive inst_ready=0, br_taken=0, br_target=0, dm_we=0, dm_addr=0 and dm_wdata=0.
REQ-034 SHALL drive inst_ready=1 on the first cycle after reset rises; an instruction in flight when reset asserts SHALL be lost without side effects.

Verification
REQ-035 SHALL pass: MOVEI r1=5; MOVEI r2=7; ADD r3=r1+r2 back-to-back, FWD_EN=1 -> r3=12 with no stall cycles, and retire_count=3.
REQ-036 SHALL pass: LOAD r4 from address 8 (mem=0x2A), then ADD r5=r4+r4 -> exactly 1 cycle with inst_ready=0, and r5=0x54.
REQ-037 SHALL pass: the REQ-035 program with FWD_EN=0 -> 2 stall cycles before ADD issues, and r3=12.
REQ-038 SHALL pass: BEQ r0,r0,imm=4 at pc 0x10 -> br_taken=1 with br_target=0x14, and the next two instructions do not change state or retire_count.
REQ-039 SHALL pass: MOVEI r0=9 followed by ADD r6=r0+r0 -> r6=0.
REQ-040 SHALL pass: reset=0 pulse during a STORE in EX -> no dm_we pulse, all outputs 0, and retire_count=0.
